dp_pipe_ctrl: RTL and testbench

- In-order 4-stage sequencer for the ARM32 datapath: ISSUE, EX, MEM, WB.
- Accepts one decoded instruction per cycle over a valid/ready handshake.
- Drives every datapath enable/select: regfile read/write addresses, forwarding selects, ALU/shift controls, status enables.
- Detects RAW hazards; forwards from EX when the datapath allows it, otherwise stalls issue.

---
 rtl/dp_ctrl_pkg.sv | 51 +++++
 rtl/dp_hazard_unit.sv | 72 +++++++
 rtl/dp_pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_dp_pipe_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ctrl_pkg.sv
// dp_ctrl_pkg: shared types and constants for the dp_pipe_ctrl sequencer.
// Holds the decoded instruction bundle, stage bundle and forwarding selects.
package dp_ctrl_pkg;

    localparam int DP_NREG   = 16;
    localparam int DP_PC_REG = 15;
    localparam int DP_AW     = $clog2(DP_NREG);

    typedef logic [DP_AW-1:0] reg_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_ALU = 2'b01;
    localparam logic [1:0] FWD_PC  = 2'b11;

    // src_used bit positions
    localparam int SRC_RN = 0;
    localparam int SRC_RM = 1;
    localparam int SRC_RS = 2;

    typedef struct packed {
        reg_t        rd;
        reg_t        rn;
        reg_t        rm;
        reg_t        rs;
        logic [2:0]  ALU_op;
        logic [1:0]  shift_op;
        logic        use_imm;
        logic [31:0] imm;
        logic [31:0] shift_imm;
        logic        use_rs;
        logic        zero_a;
        logic        no_shift;
        logic        set_flags;
        logic        wb_en;
        logic        is_load;
        logic [2:0]  src_used;
    } dp_instr_t;

    localparam int INSTR_W = $bits(dp_instr_t);

    typedef struct packed {
        logic      valid;
        dp_instr_t ins;
    } dp_stage_t;

    // True when stage s will write register src.
    function automatic logic wr_hit(input dp_stage_t s, input reg_t src);
        return s.valid & s.ins.wb_en & (s.ins.rd == src);
    endfunction

endpackage

// File: rtl/dp_hazard_unit.sv
// dp_hazard_unit: combinational RAW detection and forwarding select logic.
// Ports: i_instr (issuing), i_ex/i_mem/i_wb (stage regs); o_sel_a/b/s, o_stall.
import dp_ctrl_pkg::*;

module dp_hazard_unit #(
    parameter int PC_REG = DP_PC_REG
) (
    input  dp_instr_t  i_instr,
    input  dp_stage_t  i_ex,
    input  dp_stage_t  i_mem,
    input  dp_stage_t  i_wb,
    output logic [1:0] o_sel_a,
    output logic [1:0] o_sel_b,
    output logic [1:0] o_sel_s,
    output logic       o_stall
);

    localparam reg_t PC = reg_t'(PC_REG);

    logic [2:0] w_hz;
    logic       w_unused;

    // Only a non-load result is available on ALU_out in EX.
    function automatic logic [1:0] fwd(
        input reg_t      src,
        input logic      pc_ok,
        input dp_stage_t ex
    );
        if (pc_ok && src == PC)
            return FWD_PC;
        if (wr_hit(ex, src) && !ex.ins.is_load)
            return FWD_ALU;
        return FWD_REG;
    endfunction

    // A load in EX, or any pending write in MEM/WB, cannot be bypassed
    // (the regfile has no write-through), so the source must wait.
    function automatic logic hazard(
        input reg_t      src,
        input logic      used,
        input logic      pc_exempt,
        input dp_stage_t ex,
        input dp_stage_t mem,
        input dp_stage_t wb
    );
        logic late;
        late = (wr_hit(ex, src) & ex.ins.is_load)
             | wr_hit(mem, src)
             | wr_hit(wb, src);
        return used & !(pc_exempt && src == PC) & late;
    endfunction

    assign o_sel_a = fwd(i_instr.rn, 1'b1, i_ex);
    assign o_sel_b = fwd(i_instr.rm, 1'b0, i_ex);
    assign o_sel_s = fwd(i_instr.rs, 1'b0, i_ex);

    assign w_hz[SRC_RN] = hazard(i_instr.rn,
                                 i_instr.src_used[SRC_RN], 1'b1,
                                 i_ex, i_mem, i_wb);
    assign w_hz[SRC_RM] = hazard(i_instr.rm,
                                 i_instr.src_used[SRC_RM], 1'b0,
                                 i_ex, i_mem, i_wb);
    assign w_hz[SRC_RS] = hazard(i_instr.rs,
                                 i_instr.src_used[SRC_RS], 1'b0,
                                 i_ex, i_mem, i_wb);

    assign o_stall = |w_hz;

    // Most instruction fields are irrelevant to hazard detection.
    assign w_unused = ^{i_instr, i_ex, i_mem, i_wb};

endmodule

// File: rtl/dp_pipe_ctrl.sv
// dp_pipe_ctrl: in-order ISSUE/EX/MEM/WB sequencer driving datapath controls.
// Ports: handshake, flush, regfile addrs, fwd selects, EX/MEM/WB enables.
// Optional DP_PERF_CNT_EN adds retire_cnt / stall_cnt counters.
import dp_ctrl_pkg::*;

module dp_pipe_ctrl #(
    parameter int NREG   = DP_NREG,
    parameter int PC_REG = DP_PC_REG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INSTR_W-1:0]      instr,
    input  logic                    flush,
    output logic [$clog2(NREG)-1:0] A_addr,
    output logic [$clog2(NREG)-1:0] B_addr,
    output logic [$clog2(NREG)-1:0] shift_addr,
    output logic [1:0]              sel_A_in,
    output logic [1:0]              sel_B_in,
    output logic [1:0]              sel_shift_in,
    output logic                    en_A,
    output logic                    en_B,
    output logic                    en_S,
    output logic                    sel_shift,
    output logic [2:0]              ALU_op,
    output logic [1:0]              shift_op,
    output logic                    sel_A,
    output logic                    sel_B,
    output logic                    sel_post_shift,
    output logic                    en_out1,
    output logic                    en_status1,
    output logic [31:0]             imme_data,
    output logic [31:0]             shift_imme,
    output logic                    en_out2,
    output logic                    en_status2,
    output logic [$clog2(NREG)-1:0] w_addr1,
    output logic                    w_en1,
    output logic                    sel_w_data,
    output logic                    busy
`ifdef DP_PERF_CNT_EN
    ,
    output logic [31:0]             retire_cnt,
    output logic [31:0]             stall_cnt
`endif
);

    dp_instr_t  w_in;
    dp_stage_t  r_ex;
    dp_stage_t  r_mem;
    dp_stage_t  r_wb;
    logic       w_stall;
    logic       w_fire;
    logic       w_exv;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;
    logic [1:0] w_sel_s;

    assign w_in = dp_instr_t'(instr);

    dp_hazard_unit #(
        .PC_REG (PC_REG)
    ) u_hazard (
        .i_instr (w_in),
        .i_ex    (r_ex),
        .i_mem   (r_mem),
        .i_wb    (r_wb),
        .o_sel_a (w_sel_a),
        .o_sel_b (w_sel_b),
        .o_sel_s (w_sel_s),
        .o_stall (w_stall)
    );

    assign in_ready = !rst & !w_stall & !flush;
    assign w_fire   = in_valid & in_ready;

    // Stage advance; a flushed EX entry moves on as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb        <= r_mem;
            r_mem       <= r_ex;
            r_mem.valid <= r_ex.valid & !flush;
            r_ex.valid  <= w_fire;
            if (w_fire)
                r_ex.ins <= w_in;
        end
    end

    // ISSUE stage
    assign A_addr     = w_in.rn;
    assign B_addr     = w_in.rm;
    assign shift_addr = w_in.rs;
    assign en_A       = w_fire;
    assign en_B       = w_fire;
    assign en_S       = w_fire & w_in.use_rs;
    assign sel_shift  = !rst & w_in.use_rs;
    assign shift_imme = w_in.shift_imm;

    // Selects are held at register-file path while in reset.
    assign sel_A_in     = rst ? FWD_REG : w_sel_a;
    assign sel_B_in     = rst ? FWD_REG : w_sel_b;
    assign sel_shift_in = rst ? FWD_REG : w_sel_s;

    // EX stage
    assign w_exv          = r_ex.valid;
    assign ALU_op         = w_exv ? r_ex.ins.ALU_op   : '0;
    assign shift_op       = w_exv ? r_ex.ins.shift_op : '0;
    assign sel_A          = w_exv & r_ex.ins.zero_a;
    assign sel_B          = w_exv & r_ex.ins.use_imm;
    assign sel_post_shift = w_exv & r_ex.ins.no_shift;
    assign imme_data      = w_exv ? r_ex.ins.imm : '0;
    assign en_out1        = w_exv;
    assign en_status1     = w_exv & r_ex.ins.set_flags;

    // MEM stage
    assign en_out2    = r_mem.valid;
    assign en_status2 = r_mem.valid & r_mem.ins.set_flags;

    // WB stage
    assign w_en1      = r_wb.valid & r_wb.ins.wb_en;
    assign w_addr1    = r_wb.valid ? r_wb.ins.rd : '0;
    assign sel_w_data = r_wb.valid & r_wb.ins.is_load;

    assign busy = r_ex.valid | r_mem.valid | r_wb.valid;

`ifdef DP_PERF_CNT_EN
    logic r_unused_perf;

    // Every valid WB entry retires, writing or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt    <= '0;
            stall_cnt     <= '0;
            r_unused_perf <= 1'b0;
        end else begin
            r_unused_perf <= 1'b0;
            if (r_wb.valid)
                retire_cnt <= retire_cnt + 32'd1;
            if (in_valid & !in_ready & !flush)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dp_pipe_ctrl.sv
// tb_dp_pipe_ctrl: directed bench with a WB scoreboard for dp_pipe_ctrl.
// Covers throughput, forwarding, load/MEM stalls, flush and async reset.
import dp_ctrl_pkg::*;

module tb_dp_pipe_ctrl;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    dp_instr_t          instr_s;
    logic [INSTR_W-1:0] instr_b;
    logic               flush;
    logic [3:0]         A_addr, B_addr, shift_addr;
    logic [1:0]         sel_A_in, sel_B_in, sel_shift_in;
    logic               en_A, en_B, en_S, sel_shift;
    logic [2:0]         ALU_op;
    logic [1:0]         shift_op;
    logic               sel_A, sel_B, sel_post_shift;
    logic               en_out1, en_status1;
    logic [31:0]        imme_data, shift_imme;
    logic               en_out2, en_status2;
    logic [3:0]         w_addr1;
    logic               w_en1, sel_w_data, busy;
`ifdef DP_PERF_CNT_EN
    logic [31:0]        retire_cnt, stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [4:0]  sbq[$];
    logic [31:0] e_wb;

    assign instr_b = instr_s;

    dp_pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instr          (instr_b),
        .flush          (flush),
        .A_addr         (A_addr),
        .B_addr         (B_addr),
        .shift_addr     (shift_addr),
        .sel_A_in       (sel_A_in),
        .sel_B_in       (sel_B_in),
        .sel_shift_in   (sel_shift_in),
        .en_A           (en_A),
        .en_B           (en_B),
        .en_S           (en_S),
        .sel_shift      (sel_shift),
        .ALU_op         (ALU_op),
        .shift_op       (shift_op),
        .sel_A          (sel_A),
        .sel_B          (sel_B),
        .sel_post_shift (sel_post_shift),
        .en_out1        (en_out1),
        .en_status1     (en_status1),
        .imme_data      (imme_data),
        .shift_imme     (shift_imme),
        .en_out2        (en_out2),
        .en_status2     (en_status2),
        .w_addr1        (w_addr1),
        .w_en1          (w_en1),
        .sel_w_data     (sel_w_data),
        .busy           (busy)
`ifdef DP_PERF_CNT_EN
        ,
        .retire_cnt     (retire_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic dp_instr_t mk(input logic [3:0] rd,
                                     input logic [3:0] rn,
                                     input logic [3:0] rm,
                                     input logic       ld,
                                     input logic [2:0] used);
        dp_instr_t d;
        d          = '0;
        d.rd       = rd;
        d.rn       = rn;
        d.rm       = rm;
        d.ALU_op   = 3'd1;
        d.wb_en    = 1'b1;
        d.is_load  = ld;
        d.src_used = used;
        return d;
    endfunction

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic md();
        @(negedge clk);
    endtask

    task automatic drv(input logic v, input dp_instr_t d);
        in_valid = v;
        instr_s  = d;
    endtask

    task automatic drain();
        drv(1'b0, '0);
        for (int i = 0; i < 4; i++) tk();
    endtask

    // WB scoreboard: push on accepted writer, pop on w_en1.
    always @(negedge clk) begin
        if (!rst && w_en1) begin
            e_wb = (sbq.size() != 0) ? {27'b0, sbq.pop_front()}
                                     : 32'hdead;
            chk("wb", {27'b0, sel_w_data, w_addr1}, e_wb);
        end
        if (!rst && in_valid && in_ready && instr_s.wb_en)
            sbq.push_back({instr_s.is_load, instr_s.rd});
    end

    initial begin
        dp_instr_t sub;
        rst   = 1'b1;
        flush = 1'b0;
        drv(1'b1, mk(4'd1, 4'd15, 4'd2, 1'b0, 3'b011));
        md();
        chk("rst_rdy",  {31'b0, in_ready}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_wen",  {31'b0, w_en1}, 0);
        chk("rst_enA",  {31'b0, en_A}, 0);
        chk("rst_selA", {30'b0, sel_A_in}, 0);
        tk();
        drv(1'b0, '0);
        rst = 1'b0;
        md();
        chk("rel_rdy", {31'b0, in_ready}, 1);

        // Back-to-back independent
        tk(); drv(1'b1, mk(4'd1, 4'd8, 4'd9, 1'b0, 3'b011));
        md(); chk("t1_rdy0", {31'b0, in_ready}, 1);
        chk("t1_enA", {31'b0, en_A}, 1);
        tk(); drv(1'b1, mk(4'd2, 4'd8, 4'd9, 1'b0, 3'b011));
        md(); chk("t1_rdy1", {31'b0, in_ready}, 1);
        chk("t1_eo1", {31'b0, en_out1}, 1);
        tk(); drv(1'b0, '0);
        md();
        tk(); md();
        chk("t1_wen3", {31'b0, w_en1}, 1);
        chk("t1_wa3",  {28'b0, w_addr1}, 1);
        tk(); md();
        chk("t1_wen4", {31'b0, w_en1}, 1);
        chk("t1_wa4",  {28'b0, w_addr1}, 2);
        tk(); md();
        chk("t1_wen5", {31'b0, w_en1}, 0);
        drain();

        // EX forwarding
        tk(); drv(1'b1, mk(4'd1, 4'd8, 4'd9, 1'b0, 3'b011));
        md();
        sub = mk(4'd3, 4'd1, 4'd4, 1'b0, 3'b011);
        sub.ALU_op    = 3'd2;
        sub.set_flags = 1'b1;
        tk(); drv(1'b1, sub);
        md(); chk("t2_selA", {30'b0, sel_A_in}, 1);
        chk("t2_selB", {30'b0, sel_B_in}, 0);
        chk("t2_rdy",  {31'b0, in_ready}, 1);
        tk(); drv(1'b0, '0);
        md(); chk("t2_alu", {29'b0, ALU_op}, 2);
        chk("t2_st1", {31'b0, en_status1}, 1);
        tk(); md();
        chk("t2_st2", {31'b0, en_status2}, 1);
        drain();

        // Load-use stall
        tk(); drv(1'b1, mk(4'd5, 4'd8, 4'd9, 1'b1, 3'b001));
        md(); chk("t3_rdy0", {31'b0, in_ready}, 1);
        tk(); drv(1'b1, mk(4'd6, 4'd0, 4'd5, 1'b0, 3'b011));
        md(); chk("t3_st1", {31'b0, in_ready}, 0);
        chk("t3_selB1", {30'b0, sel_B_in}, 0);
        tk(); md(); chk("t3_st2", {31'b0, in_ready}, 0);
        tk(); md(); chk("t3_st3", {31'b0, in_ready}, 0);
        chk("t3_wen", {31'b0, w_en1}, 1);
        chk("t3_wa",  {28'b0, w_addr1}, 5);
        chk("t3_ld",  {31'b0, sel_w_data}, 1);
        tk(); md(); chk("t3_go", {31'b0, in_ready}, 1);
        chk("t3_selB2", {30'b0, sel_B_in}, 0);
        tk();
        drain();

        // Producer in MEM
        tk(); drv(1'b1, mk(4'd1, 4'd8, 4'd9, 1'b0, 3'b011));
        md();
        tk(); drv(1'b0, '0);
        md();
        tk(); drv(1'b1, mk(4'd4, 4'd1, 4'd9, 1'b0, 3'b011));
        md(); chk("t4_st1", {31'b0, in_ready}, 0);
        tk(); md(); chk("t4_st2", {31'b0, in_ready}, 0);
        tk(); md(); chk("t4_go", {31'b0, in_ready}, 1);
        chk("t4_selA", {30'b0, sel_A_in}, 0);
        tk();
        drain();

        // Flush EX
        tk(); drv(1'b1, mk(4'd10, 4'd8, 4'd9, 1'b0, 3'b011));
        md();
        sub = mk(4'd7, 4'd8, 4'd9, 1'b0, 3'b010);
        sub.zero_a = 1'b1;
        tk(); drv(1'b1, sub);
        md();
        tk(); drv(1'b0, '0);
        flush = 1'b1;
        void'(sbq.pop_back());
        md(); chk("t5_rdy", {31'b0, in_ready}, 0);
        chk("t5_mem", {31'b0, en_out2}, 1);
        chk("t5_zA",  {31'b0, sel_A}, 1);
        tk(); flush = 1'b0;
        md(); chk("t5_eo2", {31'b0, en_out2}, 0);
        chk("t5_wen", {31'b0, w_en1}, 1);
        chk("t5_wa",  {28'b0, w_addr1}, 10);
        tk(); md();
        chk("t5_wen2", {31'b0, w_en1}, 0);
        tk(); flush = 1'b1;
        drv(1'b1, mk(4'd11, 4'd8, 4'd9, 1'b0, 3'b011));
        md(); chk("t5_idle_rdy", {31'b0, in_ready}, 0);
        chk("t5_idle_busy", {31'b0, busy}, 0);
        tk(); flush = 1'b0;
        md(); chk("t5_idle_go", {31'b0, in_ready}, 1);
        tk();
        drain();

        // Reset mid-stall with a load in MEM
        tk(); drv(1'b1, mk(4'd12, 4'd8, 4'd9, 1'b1, 3'b001));
        md();
        tk(); drv(1'b1, mk(4'd13, 4'd12, 4'd9, 1'b0, 3'b011));
        md(); chk("t6_st1", {31'b0, in_ready}, 0);
        tk(); md();
        chk("t6_st2", {31'b0, in_ready}, 0);
        chk("t6_mem", {31'b0, en_out2}, 1);
        #2;
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("t6_r_eo2",  {31'b0, en_out2}, 0);
        chk("t6_r_busy", {31'b0, busy}, 0);
        chk("t6_r_rdy",  {31'b0, in_ready}, 0);
        chk("t6_r_wen",  {31'b0, w_en1}, 0);
        chk("t6_r_enA",  {31'b0, en_A}, 0);
        chk("t6_r_selA", {30'b0, sel_A_in}, 0);
        tk(); md();
        chk("t6_r_wen2", {31'b0, w_en1}, 0);
        drv(1'b0, '0);
        tk(); rst = 1'b0;
        md(); chk("t6_rel", {31'b0, in_ready}, 1);
        chk("t6_wen3", {31'b0, w_en1}, 0);
        for (int i = 0; i < 3; i++) begin
            tk(); md();
            chk("t6_nowr", {31'b0, w_en1}, 0);
        end
`ifdef DP_PERF_CNT_EN
        chk("perf_ret", retire_cnt, 0);
        chk("perf_stl", stall_cnt, 0);
`endif
        chk("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
